// File: rtl/ds_dram_master_pkg.sv
// Shared types and widths for the 2x2 downsampling RAM initiator.
package ds_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_WR,
    ST_DUMP,
    ST_DONE
  } ds_state_t;
endpackage

// File: rtl/ds_dram_master_if.sv
// Data-RAM port: single-cycle strobes plus the preload/dump request handshake.
// Handshake: mem_rd_en/mem_wr_en are held high until the matching sticky done
// input is seen high; mem_read/mem_write act on the rising edge they are high.
interface ds_dram_master_if;
  import ds_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              mem_rd_done;
  logic              mem_wr_done;

  modport master (
    output mem_addr, mem_read, mem_write, mem_wdata, mem_rd_en, mem_wr_en,
    input  mem_rdata, mem_rd_done, mem_wr_done
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_wdata, mem_rd_en, mem_wr_en,
    output mem_rdata, mem_rd_done, mem_wr_done
  );
endinterface

// File: rtl/ds_dram_master_addr_gen.sv
// Incremental source/destination pointers and block counters for the 2x2 walk.
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int                IMG_W    = 128,
  parameter int                IMG_H    = 128,
  parameter logic [ADDR_W-1:0] SRC_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] DST_BASE = 16'h4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] src0,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] src3,
  output logic [ADDR_W-1:0] dst,
  output logic              last
);
  localparam logic [ADDR_W-1:0] ROW    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(IMG_W / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(IMG_H / 2 - 1);

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] blk_r;
  logic [ADDR_W-1:0] blk_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= SRC_BASE;
      dst_q <= DST_BASE;
      blk_r <= '0;
      blk_c <= '0;
    end else if (clear) begin
      src_q <= SRC_BASE;
      dst_q <= DST_BASE;
      blk_r <= '0;
      blk_c <= '0;
    end else if (advance) begin
      dst_q <= dst_q + ADDR_W'(1);
      // Row end also skips the odd source row already consumed by RD2/RD3.
      if (blk_c == LAST_C) begin
        src_q <= src_q + ROW + ADDR_W'(2);
        blk_c <= '0;
        blk_r <= blk_r + ADDR_W'(1);
      end else begin
        src_q <= src_q + ADDR_W'(2);
        blk_c <= blk_c + ADDR_W'(1);
      end
    end
  end

  assign src0 = src_q;
  assign src1 = src_q + ADDR_W'(1);
  assign src2 = src_q + ROW;
  assign src3 = src_q + ROW + ADDR_W'(1);
  assign dst  = dst_q;
  assign last = (blk_r == LAST_R) && (blk_c == LAST_C);
endmodule

// File: rtl/ds_dram_master.sv
// Downsampling RAM initiator: preload, 2x2 average over the image, write back, dump.
module ds_dram_master
  import ds_pkg::*;
#(
  parameter int                IMG_W    = 128,
  parameter int                IMG_H    = 128,
  parameter logic [ADDR_W-1:0] SRC_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] DST_BASE = 16'h4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output ds_state_t         state,
  ds_dram_master_if.master  mem
);
  ds_state_t         state_q;
  ds_state_t         state_d;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  sum;
  logic              clear;
  logic              advance;
  logic [ADDR_W-1:0] src0;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] src3;
  logic [ADDR_W-1:0] dst;
  logic              last;

  ds_addr_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .advance (advance),
    .src0    (src0),
    .src1    (src1),
    .src2    (src2),
    .src3    (src3),
    .dst     (dst),
    .last    (last)
  );

  assign sum   = acc_q + ACC_W'(mem.mem_rdata);
  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // rdata always belongs to the address driven one state earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:        if (start) acc_q <= '0;
        ST_RD1:         acc_q <= ACC_W'(mem.mem_rdata);
        ST_RD2, ST_RD3: acc_q <= sum;
        default:        acc_q <= acc_q;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    clear         = 1'b0;
    advance       = 1'b0;
    done          = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.mem_wdata = '0;
    mem.mem_rd_en = 1'b0;
    mem.mem_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mem.mem_rd_en = 1'b1;
        if (mem.mem_rd_done) state_d = ST_RD0;
      end
      ST_RD0: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = src0;
        state_d      = ST_RD1;
      end
      ST_RD1: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = src1;
        state_d      = ST_RD2;
      end
      ST_RD2: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = src2;
        state_d      = ST_RD3;
      end
      ST_RD3: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = src3;
        state_d      = ST_WR;
      end
      ST_WR: begin
        mem.mem_write = 1'b1;
        mem.mem_addr  = dst;
        mem.mem_wdata = sum[ACC_W-1:2];
        advance       = 1'b1;
        state_d       = last ? ST_DUMP : ST_RD0;
      end
      ST_DUMP: begin
        mem.mem_wr_en = 1'b1;
        if (mem.mem_wr_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule
